// File: rtl/debounce_scan_controller.sv
// Time-multiplexed debouncer: a prescaler tick starts a one-channel-per-clock scan through a
// shared compare/increment datapath; debounced edges are queued in a show-ahead event FIFO.
module debounce_scan_controller #(
    parameter int unsigned NUM_CHANNELS        = 4,
    parameter int unsigned SAMPLE_PERIOD_CLKS  = 50000,
    parameter int unsigned STABLE_SAMPLES_RISE = 8,
    parameter int unsigned STABLE_SAMPLES_FALL = 6,
    parameter int unsigned FIFO_DEPTH          = 4
) (
    input  logic                              IN_CLOCK,
    input  logic                              IN_RESET_N,
    input  logic [NUM_CHANNELS-1:0]           IN_SIGNALS,
    input  logic                              IN_ENABLE,
    output logic [NUM_CHANNELS-1:0]           OUT_DEBOUNCE_SIGNALS,
    output logic                              OUT_EVENT_VALID,
    output logic [$clog2(NUM_CHANNELS)-1:0]   OUT_EVENT_CHANNEL,
    output logic                              OUT_EVENT_RISE,
    input  logic                              IN_EVENT_READY,
    output logic                              OUT_EVENT_OVERFLOW,
    input  logic                              IN_OVERFLOW_CLEAR
);

    localparam int unsigned CH_W       = $clog2(NUM_CHANNELS);
    localparam int unsigned MAX_STABLE = (STABLE_SAMPLES_RISE > STABLE_SAMPLES_FALL) ?
                                         STABLE_SAMPLES_RISE : STABLE_SAMPLES_FALL;
    localparam int unsigned CNT_W      = $clog2(MAX_STABLE) + 1;
    localparam int unsigned PRE_W      = $clog2(SAMPLE_PERIOD_CLKS);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W     = PTR_W + 1;

    // Parameter sanity checks at elaboration
    if (NUM_CHANNELS < 2) begin : g_chk_channels
        $error("NUM_CHANNELS must be >= 2");
    end
    if (SAMPLE_PERIOD_CLKS <= NUM_CHANNELS + 1) begin : g_chk_period
        $error("SAMPLE_PERIOD_CLKS must exceed NUM_CHANNELS+1 so scans never overlap");
    end
    if (STABLE_SAMPLES_RISE < 1 || STABLE_SAMPLES_FALL < 1) begin : g_chk_stable
        $error("STABLE_SAMPLES_RISE/FALL must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0] channel;
        logic            rise;
    } event_t;

    logic [NUM_CHANNELS-1:0] sync1_q;
    logic [NUM_CHANNELS-1:0] sync2_q;
    logic [PRE_W-1:0]        pre_q;
    logic                    tick_c;

    state_t                  state_q;
    logic [CH_W-1:0]         idx_q;
    logic [NUM_CHANNELS-1:0] sample_q;
    logic [NUM_CHANNELS-1:0] deb_q;
    logic [CNT_W-1:0]        cnt_q [NUM_CHANNELS];

    logic                    cur_smp_c;
    logic                    cur_deb_c;
    logic [CNT_W-1:0]        cnt_inc_c;
    logic [CNT_W-1:0]        thresh_c;
    logic                    push_c;
    event_t                  push_ev_c;

    event_t                  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [FCNT_W-1:0]       count_q;
    logic                    valid_q;
    event_t                  head_q;
    logic                    ovf_q;

    logic                    pop_c;
    logic                    full_c;
    logic                    push_ok_c;
    logic                    ovf_set_c;
    logic [FCNT_W-1:0]       remain_c;
    logic [FCNT_W-1:0]       count_next_c;
    logic [PTR_W-1:0]        rd_next_c;
    event_t                  head_next_c;

    // Two-flop synchroniser for the raw contacts
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= IN_SIGNALS;
            sync2_q <= sync1_q;
        end
    end

    assign tick_c = IN_ENABLE && (pre_q == PRE_W'(SAMPLE_PERIOD_CLKS - 1));

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            pre_q <= '0;
        end else if (!IN_ENABLE || tick_c) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Shared per-channel compare/increment datapath
    always_comb begin
        cur_smp_c         = sample_q[idx_q];
        cur_deb_c         = deb_q[idx_q];
        cnt_inc_c         = cnt_q[idx_q] + CNT_W'(1);
        thresh_c          = cur_smp_c ? CNT_W'(STABLE_SAMPLES_RISE) : CNT_W'(STABLE_SAMPLES_FALL);
        push_c            = (state_q == ST_SCAN) && (cur_smp_c != cur_deb_c) && (cnt_inc_c == thresh_c);
        push_ev_c.channel = idx_q;
        push_ev_c.rise    = cur_smp_c;
    end

    // Scan FSM; ignores IN_ENABLE once started so a scan always completes
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sample_q <= '0;
            deb_q    <= '0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_c) begin
                        sample_q <= sync2_q;
                        idx_q    <= '0;
                        state_q  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cur_smp_c == cur_deb_c) begin
                        cnt_q[idx_q] <= '0;
                    end else if (cnt_inc_c == thresh_c) begin
                        deb_q[idx_q] <= cur_smp_c;
                        cnt_q[idx_q] <= '0;
                    end else begin
                        cnt_q[idx_q] <= cnt_inc_c;
                    end
                    if (idx_q == CH_W'(NUM_CHANNELS - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + CH_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO control; the head is pre-computed so the output fields come straight from flops
    always_comb begin
        pop_c        = valid_q && IN_EVENT_READY;
        full_c       = (count_q == FCNT_W'(FIFO_DEPTH));
        push_ok_c    = push_c && (!full_c || pop_c);
        ovf_set_c    = push_c && full_c && !pop_c;
        remain_c     = count_q - FCNT_W'(pop_c);
        count_next_c = remain_c + FCNT_W'(push_ok_c);
        rd_next_c    = rd_ptr_q + PTR_W'(pop_c);
        head_next_c  = (remain_c == '0) ? push_ev_c : mem_q[rd_next_c];
    end

    always_ff @(posedge IN_CLOCK) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_ev_c;
        end
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_next_c;
            count_q  <= count_next_c;
            valid_q  <= (count_next_c != '0);
            if (count_next_c != '0) begin
                head_q <= head_next_c;
            end
            if (ovf_set_c) begin
                ovf_q <= 1'b1;
            end else if (IN_OVERFLOW_CLEAR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign OUT_DEBOUNCE_SIGNALS = deb_q;
    assign OUT_EVENT_VALID      = valid_q;
    assign OUT_EVENT_CHANNEL    = head_q.channel;
    assign OUT_EVENT_RISE       = head_q.rise;
    assign OUT_EVENT_OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_debounce_scan_controller.sv
// Directed bench for debounce_scan_controller: vector table for the main flows, hand sequences
// for reset and enable corner cases.
module tb_debounce_scan_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] sig;
    logic       en;
    logic [3:0] deb;
    logic       valid;
    logic [1:0] ch;
    logic       rise;
    logic       rdy;
    logic       ovf;
    logic       clr;

    int n_checks;
    int n_pass;
    int ev_count;

    typedef struct {
        logic [3:0] sig;
        logic       en;
        logic       rdy;
        logic       clr;
        int         steps;
        logic [3:0] e_deb;
        logic       e_valid;
        logic [1:0] e_ch;
        logic       e_rise;
        logic       e_ovf;
        string      name;
    } vec_t;

    vec_t vecs[$];

    debounce_scan_controller #(
        .NUM_CHANNELS(4),
        .SAMPLE_PERIOD_CLKS(10),
        .STABLE_SAMPLES_RISE(3),
        .STABLE_SAMPLES_FALL(2),
        .FIFO_DEPTH(4)
    ) dut (
        .IN_CLOCK(clk),
        .IN_RESET_N(rst_n),
        .IN_SIGNALS(sig),
        .IN_ENABLE(en),
        .OUT_DEBOUNCE_SIGNALS(deb),
        .OUT_EVENT_VALID(valid),
        .OUT_EVENT_CHANNEL(ch),
        .OUT_EVENT_RISE(rise),
        .IN_EVENT_READY(rdy),
        .OUT_EVENT_OVERFLOW(ovf),
        .IN_OVERFLOW_CLEAR(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes observed mid-cycle, each one accepted at the following edge
    initial ev_count = 0;
    always @(negedge clk) begin
        if (rst_n && valid && rdy) ev_count <= ev_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] e_deb, input logic e_valid,
                             input logic [1:0] e_ch, input logic e_rise, input logic e_ovf,
                             input logic head);
        logic ok;
        ok = (deb === e_deb) && (valid === e_valid) && (ovf === e_ovf);
        if (head) ok = ok && (ch === e_ch) && (rise === e_rise);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got deb=%b valid=%b ch=%0d rise=%b ovf=%b, want deb=%b valid=%b ch=%0d rise=%b ovf=%b",
                      name, deb, valid, ch, rise, ovf, e_deb, e_valid, e_ch, e_rise, e_ovf);
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    endtask

    task automatic add(input logic [3:0] s, input logic e, input logic r, input logic c, input int st,
                       input logic [3:0] d, input logic v, input logic [1:0] k, input logic ri,
                       input logic o, input string nm);
        vec_t x;
        x.sig = s; x.en = e; x.rdy = r; x.clr = c; x.steps = st;
        x.e_deb = d; x.e_valid = v; x.e_ch = k; x.e_rise = ri; x.e_ovf = o; x.name = nm;
        vecs.push_back(x);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset with random inputs
        rst_n = 1'b0;
        sig   = 4'($urandom);
        en    = 1'($urandom);
        rdy   = 1'($urandom);
        clr   = 1'($urandom);
        repeat (3) step();
        check_out("reset_outputs", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        en    = 1'b0;
        rdy   = 1'b1;
        clr   = 1'b0;
        rst_n = 1'b1;
        repeat (100) step();
        check_out("disabled_no_tick", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check_int("disabled_no_events", ev_count, 0);

        // Single channel rise then fall (ticks snapshot at +10, +20, +30 ...)
        add(4'b0100, 1, 1, 0, 23, 4'b0000, 0, 0, 0, 0, "t2_two_highs");
        add(4'b0100, 1, 1, 0,  9, 4'b0000, 0, 0, 0, 0, "t2_before_rise");
        add(4'b0100, 1, 1, 0,  1, 4'b0100, 1, 2, 1, 0, "t2_rise_event");
        add(4'b0100, 1, 1, 0,  1, 4'b0100, 0, 0, 0, 0, "t2_rise_one_cycle");
        add(4'b0000, 1, 1, 0, 18, 4'b0100, 0, 0, 0, 0, "t2_before_fall");
        add(4'b0000, 1, 1, 0,  1, 4'b0000, 1, 2, 0, 0, "t2_fall_event");
        add(4'b0000, 1, 1, 0,  1, 4'b0000, 0, 0, 0, 0, "t2_fall_one_cycle");
        // Chatter 1,1,0 on ch0 never reaches three stable highs
        for (int r = 0; r < 10; r++) begin
            add(4'b0001, 1, 1, 0, 10, 4'b0000, 0, 0, 0, 0, "t3_high_a");
            add(4'b0001, 1, 1, 0, 10, 4'b0000, 0, 0, 0, 0, "t3_high_b");
            add(4'b0000, 1, 1, 0, 10, 4'b0000, 0, 0, 0, 0, "t3_low");
        end
        // All channels rise together
        add(4'b1111, 1, 1, 0, 26, 4'b0000, 0, 0, 0, 0, "t4_before");
        add(4'b1111, 1, 1, 0,  1, 4'b0001, 1, 0, 1, 0, "t4_ev_ch0");
        add(4'b1111, 1, 1, 0,  1, 4'b0011, 1, 1, 1, 0, "t4_ev_ch1");
        add(4'b1111, 1, 1, 0,  1, 4'b0111, 1, 2, 1, 0, "t4_ev_ch2");
        add(4'b1111, 1, 1, 0,  1, 4'b1111, 1, 3, 1, 0, "t4_ev_ch3");
        add(4'b1111, 1, 1, 0,  1, 4'b1111, 0, 0, 0, 0, "t4_drained");
        // Return to all-low, then overflow with READY held low
        add(4'b0000, 1, 1, 0, 16, 4'b1110, 1, 0, 0, 0, "t5_prep_fall_ch0");
        add(4'b0000, 1, 1, 0,  4, 4'b0000, 0, 0, 0, 0, "t5_prep_done");
        add(4'b1111, 1, 0, 0, 29, 4'b1111, 1, 0, 1, 0, "t5_fifo_full");
        add(4'b0000, 1, 0, 0, 17, 4'b1110, 1, 0, 1, 1, "t5_first_drop");
        add(4'b0000, 1, 0, 0,  3, 4'b0000, 1, 0, 1, 1, "t5_all_dropped");
        add(4'b0000, 1, 1, 0,  0, 4'b0000, 1, 0, 1, 1, "t5_drain_ch0");
        add(4'b0000, 1, 1, 0,  1, 4'b0000, 1, 1, 1, 1, "t5_drain_ch1");
        add(4'b0000, 1, 1, 0,  1, 4'b0000, 1, 2, 1, 1, "t5_drain_ch2");
        add(4'b0000, 1, 1, 0,  1, 4'b0000, 1, 3, 1, 1, "t5_drain_ch3");
        add(4'b0000, 1, 1, 0,  1, 4'b0000, 0, 0, 0, 1, "t5_drain_empty");
        add(4'b0000, 1, 1, 0,  5, 4'b0000, 0, 0, 0, 1, "t5_stays_empty");
        add(4'b0000, 1, 1, 1,  1, 4'b0000, 0, 0, 0, 0, "t5_clear");
        add(4'b0000, 1, 1, 0,  1, 4'b0000, 0, 0, 0, 0, "t5_cleared");

        for (int i = 0; i < vecs.size(); i++) begin
            sig = vecs[i].sig;
            en  = vecs[i].en;
            rdy = vecs[i].rdy;
            clr = vecs[i].clr;
            repeat (vecs[i].steps) step();
            check_out(vecs[i].name, vecs[i].e_deb, vecs[i].e_valid, vecs[i].e_ch,
                      vecs[i].e_rise, vecs[i].e_ovf, vecs[i].e_valid);
        end
        check_int("table_event_total", ev_count, 14);

        // Reset while scanning idx=1 with ch1 about to rise
        sig = 4'b0011;
        repeat (26) step();
        check_out("t6_ch0_rose", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("t6_async_reset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        sig = 4'b0000;
        en  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (30) step();
        check_out("t6_after_release", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check_int("t6_no_events", ev_count, 14);

        // Enable dropped mid-scan: the scan still finishes and ch3 rises
        sig = 4'b1000;
        en  = 1'b1;
        repeat (31) step();
        en = 1'b0;
        check_out("t6_mid_scan", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check_out("t6_scan_completed", 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
        sig = 4'b0000;
        repeat (60) step();
        check_out("t6_no_more_ticks", 4'b1000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_int("t6_event_total", ev_count, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
